// File: rtl/mcpu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : if_io
// Brief    : LED output bundle driven by mcpu_core toward the board ffd.
// Revision : 1.0 - initial release
// ============================================================================
interface if_io;
    logic       LEDS_WE;
    logic [7:0] LEDS_WD;

    modport cpu   (output LEDS_WE, LEDS_WD);
    modport board (input  LEDS_WE, LEDS_WD);
endinterface
`default_nettype wire

// File: rtl/mcpu_core.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_core
// Brief    : Single-cycle 8-bit load/store CPU with ROM, 8x8 regfile, 256x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_core #(
    parameter string PROG_FILE = "prog.hex",
    parameter int    PC_W      = 8
) (
    input  logic CLK,
    input  logic RESET,
    if_io.cpu    IO
);
    localparam int         c_ROM_DEPTH = 2**PC_W;
    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_SHL  = 4'h7;
    localparam logic [3:0] c_OP_SHR  = 4'h8;
    localparam logic [3:0] c_OP_LD   = 4'h9;
    localparam logic [3:0] c_OP_ST   = 4'hA;
    localparam logic [3:0] c_OP_OUT  = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;
    localparam logic [3:0] c_OP_BZ   = 4'hD;
    localparam logic [3:0] c_OP_BNZ  = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    logic [15:0]     r_rom  [0:c_ROM_DEPTH-1];
    logic [7:0]      r_ram  [0:255];
    logic [7:0]      r_regs [0:7];
    logic [PC_W-1:0] r_pc;
    logic            r_halted;

    logic [15:0]     w_instr;
    logic [3:0]      w_op;
    logic [2:0]      w_rd, w_rs, w_rt;
    logic [7:0]      w_imm, w_rd_val, w_rs_val, w_rt_val, w_rf_wd;
    logic            w_rf_we, w_active, w_out, w_ram_we, w_halt;
    logic [PC_W-1:0] w_pc_next;

    assign w_instr  = r_rom[r_pc];
    assign w_op     = w_instr[15:12];
    assign w_rd     = w_instr[11:9];
    assign w_rs     = w_instr[8:6];
    assign w_rt     = w_instr[5:3];
    assign w_imm    = w_instr[7:0];
    assign w_rd_val = (w_rd == 3'd0) ? 8'h00 : r_regs[w_rd];
    assign w_rs_val = (w_rs == 3'd0) ? 8'h00 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? 8'h00 : r_regs[w_rt];

    assign w_active = !RESET && !r_halted;
    assign w_out    = w_active && (w_op == c_OP_OUT);
    assign w_ram_we = w_active && (w_op == c_OP_ST);
    assign w_halt   = (w_op == c_OP_HALT);

    assign IO.LEDS_WE = w_out;
    assign IO.LEDS_WD = w_out ? w_rd_val : 8'h00;

    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_wd   = 8'h00;
        w_pc_next = r_pc + PC_W'(1);
        case (w_op)
            c_OP_NOP:  ;
            c_OP_LDI:  begin w_rf_we = 1'b1; w_rf_wd = w_imm;               end
            c_OP_ADD:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val + w_rt_val; end
            c_OP_SUB:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val - w_rt_val; end
            c_OP_AND:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val & w_rt_val; end
            c_OP_OR:   begin w_rf_we = 1'b1; w_rf_wd = w_rs_val | w_rt_val; end
            c_OP_XOR:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val ^ w_rt_val; end
            c_OP_SHL:  begin w_rf_we = 1'b1; w_rf_wd = {w_rs_val[6:0], 1'b0}; end
            c_OP_SHR:  begin w_rf_we = 1'b1; w_rf_wd = {1'b0, w_rs_val[7:1]}; end
            c_OP_LD:   begin w_rf_we = 1'b1; w_rf_wd = r_ram[w_rs_val];     end
            c_OP_ST:   ;
            c_OP_OUT:  ;
            c_OP_JMP:  w_pc_next = PC_W'(w_imm);
            c_OP_BZ:   if (w_rd_val == 8'h00) w_pc_next = PC_W'(w_imm);
            c_OP_BNZ:  if (w_rd_val != 8'h00) w_pc_next = PC_W'(w_imm);
            c_OP_HALT: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
        end else if (!r_halted) begin
            r_pc <= w_pc_next;
            if (w_rf_we && (w_rd != 3'd0)) r_regs[w_rd] <= w_rf_wd;
            if (w_halt) r_halted <= 1'b1;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (w_ram_we) r_ram[w_rs_val] <= w_rd_val;
    end
endmodule
`default_nettype wire

// File: tb/tb_mcpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_core
// Brief    : Directed self-checking bench for mcpu_core with a board-side ffd model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_core;
    logic CLK;
    logic RESET;
    if_io io ();

    int compared   = 0;
    int mismatched = 0;
    logic [7:0]  ffd_q;
    logic [15:0] prog [$];
    logic [7:0]  logged [$];
    logic [7:0]  expect_q [$];
    int          cnt;

    mcpu_core #(.PROG_FILE(""), .PC_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .IO    (io)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (RESET)           ffd_q <= 8'h00;
        else if (io.LEDS_WE) ffd_q <= io.LEDS_WD;
    end

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) dut.r_rom[i] = 16'h0000;
        for (int i = 0; i < prog.size(); i++) dut.r_rom[i] = prog[i];
        prog.delete();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
    endtask

    task automatic run_log(input int n);
        logged.delete();
        for (int i = 0; i < n; i++) begin
            if (io.LEDS_WE) logged.push_back(io.LEDS_WD);
            tick();
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, logged.size(), expect_q.size());
        for (int i = 0; i < expect_q.size() && i < logged.size(); i++)
            check($sformatf("%s_%0d", tag, i), logged[i], expect_q[i]);
        expect_q.delete();
    endtask

    initial begin
        // Reset with OUT as the first word, then free-run NOPs to the PC wrap.
        prog.push_back(enc_i(4'hB, 3'd1, 8'h00));
        load();
        RESET = 1'b1;
        #1;
        check("rst_we_a", io.LEDS_WE, 1'b0);
        tick();
        check("rst_we_b", io.LEDS_WE, 1'b0);
        tick();
        check("rst_we_c", io.LEDS_WE, 1'b0);
        check("rst_ffd", ffd_q, 8'h00);
        RESET = 1'b0;
        #1;
        check("rst_pc", dut.r_pc, 8'h00);
        check("rst_first_out_we", io.LEDS_WE, 1'b1);
        check("rst_first_out_wd", io.LEDS_WD, 8'h00);
        cnt = 0;
        do begin tick(); cnt++; end while (!io.LEDS_WE && cnt < 300);
        check("wrap_period", cnt, 256);

        // JMP to 0xFF then a NOP: the following fetch comes from address 0.
        prog.push_back(enc_i(4'h1, 3'd1, 8'h07));
        prog.push_back(enc_i(4'hB, 3'd1, 8'h00));
        prog.push_back(enc_i(4'hC, 3'd0, 8'hFF));
        load();
        do_reset();
        tick();
        check("jmp_out_wd", io.LEDS_WD, 8'h07);
        cnt = 0;
        do begin tick(); cnt++; end while (!io.LEDS_WE && cnt < 20);
        check("jmp_wrap_gap", cnt, 4);

        // Arithmetic with mod-256 wrap.
        prog.push_back(enc_i(4'h1, 3'd1, 8'hF0));
        prog.push_back(enc_i(4'h1, 3'd2, 8'h20));
        prog.push_back(enc_r(4'h2, 3'd3, 3'd1, 3'd2));
        prog.push_back(enc_i(4'hB, 3'd3, 8'h00));
        prog.push_back(enc_r(4'h3, 3'd4, 3'd2, 3'd1));
        prog.push_back(enc_i(4'hB, 3'd4, 8'h00));
        prog.push_back(enc_i(4'hF, 3'd0, 8'h00));
        load();
        do_reset();
        run_log(12);
        expect_q.push_back(8'h10);
        expect_q.push_back(8'h30);
        check_log("arith");
        check("arith_halt_we", io.LEDS_WE, 1'b0);
        check("arith_halt_pc", dut.r_pc, 8'h06);
        check("arith_ffd", ffd_q, 8'h30);

        // Store/load at address 5, 0 and 255.
        prog.push_back(enc_i(4'h1, 3'd1, 8'h05));
        prog.push_back(enc_i(4'h1, 3'd2, 8'hA5));
        prog.push_back(enc_r(4'hA, 3'd2, 3'd1, 3'd0));
        prog.push_back(enc_r(4'h9, 3'd3, 3'd1, 3'd0));
        prog.push_back(enc_i(4'hB, 3'd3, 8'h00));
        prog.push_back(enc_i(4'h1, 3'd4, 8'h3C));
        prog.push_back(enc_r(4'hA, 3'd4, 3'd0, 3'd0));
        prog.push_back(enc_r(4'h9, 3'd5, 3'd0, 3'd0));
        prog.push_back(enc_i(4'hB, 3'd5, 8'h00));
        prog.push_back(enc_i(4'h1, 3'd6, 8'hFF));
        prog.push_back(enc_i(4'h1, 3'd7, 8'hC3));
        prog.push_back(enc_r(4'hA, 3'd7, 3'd6, 3'd0));
        prog.push_back(enc_r(4'h9, 3'd1, 3'd6, 3'd0));
        prog.push_back(enc_i(4'hB, 3'd1, 8'h00));
        prog.push_back(enc_r(4'h9, 3'd2, 3'd0, 3'd0));
        prog.push_back(enc_i(4'hB, 3'd2, 8'h00));
        prog.push_back(enc_i(4'hF, 3'd0, 8'h00));
        load();
        do_reset();
        run_log(22);
        expect_q.push_back(8'hA5);
        expect_q.push_back(8'h3C);
        expect_q.push_back(8'hC3);
        expect_q.push_back(8'h3C);
        check_log("mem");

        // Countdown loop, then a reset landing on a live OUT.
        prog.push_back(enc_i(4'h1, 3'd1, 8'h03));
        prog.push_back(enc_i(4'hB, 3'd1, 8'h00));
        prog.push_back(enc_i(4'h1, 3'd2, 8'h01));
        prog.push_back(enc_r(4'h3, 3'd1, 3'd1, 3'd2));
        prog.push_back(enc_i(4'hE, 3'd1, 8'h01));
        prog.push_back(enc_i(4'hF, 3'd0, 8'h00));
        load();
        do_reset();
        run_log(25);
        expect_q.push_back(8'h03);
        expect_q.push_back(8'h02);
        expect_q.push_back(8'h01);
        check_log("loop");
        check("loop_ffd", ffd_q, 8'h01);
        check("loop_halt_we", io.LEDS_WE, 1'b0);
        check("loop_halt_pc", dut.r_pc, 8'h05);

        do_reset();
        tick();
        check("mid_out_live", io.LEDS_WE, 1'b1);
        RESET = 1'b1;
        #1;
        check("mid_out_suppressed", io.LEDS_WE, 1'b0);
        tick();
        RESET = 1'b0;
        #1;
        check("mid_reset_pc", dut.r_pc, 8'h00);
        run_log(25);
        expect_q.push_back(8'h03);
        expect_q.push_back(8'h02);
        expect_q.push_back(8'h01);
        check_log("loop_again");

        // r0 hardwiring, shifts, logic ops and BZ taken/not taken.
        prog.push_back(enc_i(4'h1, 3'd0, 8'hFF));
        prog.push_back(enc_i(4'hB, 3'd0, 8'h00));
        prog.push_back(enc_i(4'h1, 3'd1, 8'h81));
        prog.push_back(enc_r(4'h7, 3'd2, 3'd1, 3'd0));
        prog.push_back(enc_r(4'h8, 3'd3, 3'd1, 3'd0));
        prog.push_back(enc_i(4'hB, 3'd2, 8'h00));
        prog.push_back(enc_i(4'hB, 3'd3, 8'h00));
        prog.push_back(enc_i(4'h1, 3'd4, 8'hC3));
        prog.push_back(enc_r(4'h4, 3'd5, 3'd1, 3'd4));
        prog.push_back(enc_r(4'h5, 3'd6, 3'd1, 3'd4));
        prog.push_back(enc_r(4'h6, 3'd7, 3'd1, 3'd4));
        prog.push_back(enc_i(4'hB, 3'd5, 8'h00));
        prog.push_back(enc_i(4'hB, 3'd6, 8'h00));
        prog.push_back(enc_i(4'hB, 3'd7, 8'h00));
        prog.push_back(enc_i(4'hD, 3'd4, 8'h20));
        prog.push_back(enc_i(4'hD, 3'd0, 8'h11));
        prog.push_back(enc_i(4'hB, 3'd1, 8'h00));
        prog.push_back(enc_i(4'hB, 3'd4, 8'h00));
        prog.push_back(enc_i(4'hF, 3'd0, 8'h00));
        load();
        do_reset();
        run_log(25);
        expect_q.push_back(8'h00);
        expect_q.push_back(8'h02);
        expect_q.push_back(8'h40);
        expect_q.push_back(8'h81);
        expect_q.push_back(8'hC3);
        expect_q.push_back(8'h42);
        expect_q.push_back(8'hC3);
        check_log("misc");
        check("misc_halt_pc", dut.r_pc, 8'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
